// File: rtl/hdmi_pattern_gen_pkg.sv
// Shared constants for the HDMI test-pattern generator: mode encodings,
// colour constants and the colour-bar lookup table.
package hdmi_pattern_pkg;

    // Pattern select values carried on cfg_mode; 6 and 7 fall back to SOLID
    typedef enum logic [2:0] {
        MODE_SOLID  = 3'd0,
        MODE_BARS   = 3'd1,
        MODE_HGRAD  = 3'd2,
        MODE_CHECK  = 3'd3,
        MODE_SCROLL = 3'd4,
        MODE_GRID   = 3'd5
    } pattern_mode_e;

    // Pixel payload plus the valid flag that travels with it
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned FRAME_W = PIX_W + 1;

    localparam logic [PIX_W-1:0] RGB_BLACK = 24'h000000;
    localparam logic [PIX_W-1:0] RGB_WHITE = 24'hFFFFFF;

    // Classic 8-bar order, left to right, {R,G,B}
    localparam logic [PIX_W-1:0] BAR_TABLE [8] = '{
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'h00FF00,   // green
        24'hFF00FF,   // magenta
        24'hFF0000,   // red
        24'h0000FF,   // blue
        24'h000000    // black
    };

endpackage

// File: rtl/hdmi_pattern_gen_if.sv
// Pixel request/response bundle between hdmi_tx_top (master) and the
// pattern generator (slave), plus the frame-latched configuration.
interface hdmi_pattern_gen_if;

    logic [2:0]  cfg_mode;
    logic [23:0] cfg_color;
    logic        req_en;
    logic        req_sof;
    logic        req_sol;
    logic [7:0]  resp_red;
    logic [7:0]  resp_green;
    logic [7:0]  resp_blue;
    logic        err_overrun;

    modport master (
        output cfg_mode,
        output cfg_color,
        output req_en,
        output req_sof,
        output req_sol,
        input  resp_red,
        input  resp_green,
        input  resp_blue,
        input  err_overrun
    );

    modport slave (
        input  cfg_mode,
        input  cfg_color,
        input  req_en,
        input  req_sof,
        input  req_sol,
        output resp_red,
        output resp_green,
        output resp_blue,
        output err_overrun
    );

endinterface

// File: rtl/hdmi_pattern_gen_delay_line.sv
// Fixed-depth shift register that pads the pixel path out to the
// requested response latency. Clear is synchronous, active low.
module pattern_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stages [DEPTH];

    // Shift one stage per clock; clearing drops every in-flight pixel
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stages <= '{default: '0};
        end else begin
            r_stages[0] <= i_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_data = r_stages[DEPTH-1];

endmodule

// File: rtl/hdmi_pattern_gen.sv
// HDMI test-pattern source: tracks raster position from the request
// strobes, renders one of six patterns and returns each pixel a fixed
// number of cycles after its request. Geometry violations are sticky.
module hdmi_pattern_gen
    import hdmi_pattern_pkg::*;
#(
    parameter int unsigned RESP_LATENCY = 1,
    parameter int unsigned H_ACTIVE     = 1280,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned CHECK_LOG2   = 5,
    parameter int unsigned SCROLL_STEP  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    hdmi_pattern_gen_if.slave  bus
);

    localparam int unsigned XW       = $clog2(H_ACTIVE) + 1;
    localparam int unsigned YW       = $clog2(V_ACTIVE) + 1;
    localparam int unsigned BAR_LEN  = H_ACTIVE / 8;
    localparam int unsigned BW       = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    localparam logic [XW-1:0] X_LIMIT   = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_LIMIT   = YW'(V_ACTIVE);
    localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_LEN - 1);
    localparam logic [XW-1:0] X_CBIT    = XW'(1 << CHECK_LOG2);
    localparam logic [YW-1:0] Y_CBIT    = YW'(1 << CHECK_LOG2);
    localparam logic [XW-1:0] X_CMASK   = XW'((1 << CHECK_LOG2) - 1);
    localparam logic [YW-1:0] Y_CMASK   = YW'((1 << CHECK_LOG2) - 1);
    localparam logic [7:0]    OFS_STEP  = 8'(SCROLL_STEP);

    // Architectural state
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [BW-1:0]      r_bar_cnt;
    logic [2:0]         r_bar_idx;
    logic [7:0]         r_offset;
    logic [2:0]         r_mode;
    logic [PIX_W-1:0]   r_color;
    logic               r_first_line;
    logic               r_err;
    logic [FRAME_W-1:0] r_stage1;

    // Position/config as seen by this cycle's pixel, after SOF/SOL applied
    logic [XW-1:0]      w_x;
    logic [YW-1:0]      w_y;
    logic [YW-1:0]      w_y_base;
    logic [BW-1:0]      w_bar_cnt;
    logic [2:0]         w_bar_idx;
    logic [7:0]         w_offset;
    logic [2:0]         w_mode;
    logic [PIX_W-1:0]   w_color;
    logic               w_first;
    logic               w_first_nxt;
    logic               w_line_ovr;
    logic               w_pix_ovr;
    logic [7:0]         w_s;
    logic               w_check;
    logic               w_grid;
    logic [PIX_W-1:0]   w_pix;
    logic [FRAME_W-1:0] w_out;

    // SOF is applied before SOL so a coincident pair behaves as frame
    // start followed by the first line, and a req_en in that same cycle
    // renders against the freshly reset position and newly latched config.
    always_comb begin
        w_mode      = bus.req_sof ? bus.cfg_mode  : r_mode;
        w_color     = bus.req_sof ? bus.cfg_color : r_color;
        w_offset    = bus.req_sof ? (r_offset + OFS_STEP) : r_offset;
        w_first     = bus.req_sof ? 1'b1 : r_first_line;
        w_y_base    = bus.req_sof ? '0 : r_y;
        w_x         = r_x;
        w_bar_cnt   = r_bar_cnt;
        w_bar_idx   = r_bar_idx;
        w_y         = w_y_base;
        w_first_nxt = w_first;
        if (bus.req_sol) begin
            w_x         = '0;
            w_bar_cnt   = '0;
            w_bar_idx   = '0;
            w_first_nxt = 1'b0;
            if (!w_first) begin
                w_y = (w_y_base == Y_LIMIT) ? Y_LIMIT : (w_y_base + 1'b1);
            end
        end
        w_line_ovr = bus.req_sol && (w_y == Y_LIMIT);
        w_pix_ovr  = bus.req_en && ((w_x == X_LIMIT) || (w_y == Y_LIMIT));
    end

    // Pattern mux for the current request
    always_comb begin
        w_s     = 8'(w_x) + w_offset;
        w_check = ((w_x & X_CBIT) != '0) ^ ((w_y & Y_CBIT) != '0);
        w_grid  = ((w_x & X_CMASK) == '0) || ((w_y & Y_CMASK) == '0);
        case (w_mode)
            MODE_BARS:   w_pix = BAR_TABLE[w_bar_idx];
            MODE_HGRAD:  w_pix = {w_s, w_s, w_s};
            MODE_CHECK:  w_pix = w_check ? RGB_WHITE : RGB_BLACK;
            MODE_SCROLL: w_pix = {w_s, ~w_s, w_s};
            MODE_GRID:   w_pix = w_grid ? RGB_WHITE : RGB_BLACK;
            default:     w_pix = w_color;
        endcase
        if (w_pix_ovr) begin
            w_pix = RGB_BLACK;
        end
    end

    // Position counters, frame-latched config, sticky error and stage 1
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_x          <= '0;
            r_y          <= '0;
            r_bar_cnt    <= '0;
            r_bar_idx    <= '0;
            r_offset     <= '0;
            r_mode       <= '0;
            r_color      <= '0;
            r_first_line <= 1'b1;
            r_err        <= 1'b0;
            r_stage1     <= '0;
        end else begin
            r_mode       <= w_mode;
            r_color      <= w_color;
            r_offset     <= w_offset;
            r_first_line <= w_first_nxt;
            r_y          <= w_y;
            if (bus.req_en && !w_pix_ovr) begin
                r_x <= w_x + 1'b1;
                if (w_bar_cnt == BAR_LAST) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= w_bar_idx + 1'b1;
                end else begin
                    r_bar_cnt <= w_bar_cnt + 1'b1;
                    r_bar_idx <= w_bar_idx;
                end
            end else begin
                r_x       <= w_x;
                r_bar_cnt <= w_bar_cnt;
                r_bar_idx <= w_bar_idx;
            end
            if (w_line_ovr || w_pix_ovr) begin
                r_err <= 1'b1;
            end
            r_stage1 <= bus.req_en ? {1'b1, w_pix} : '0;
        end
    end

    generate
        if (RESP_LATENCY > 1) begin : g_delay
            pattern_delay_line #(
                .DEPTH (RESP_LATENCY - 1),
                .WIDTH (FRAME_W)
            ) u_delay (
                .clk    (clk),
                .rstn   (rstn),
                .i_data (r_stage1),
                .o_data (w_out)
            );
        end else begin : g_bypass
            assign w_out = r_stage1;
        end
    endgenerate

    // Response is forced to zero whenever no valid pixel emerges
    always_comb begin
        bus.resp_red   = w_out[FRAME_W-1] ? w_out[23:16] : '0;
        bus.resp_green = w_out[FRAME_W-1] ? w_out[15:8]  : '0;
        bus.resp_blue  = w_out[FRAME_W-1] ? w_out[7:0]   : '0;
    end

    assign bus.err_overrun = r_err;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Directed bench: two generators (latency 1 and 3) share one request
// stream; each cycle's expected pixel is logged and compared at the
// point it must emerge from each instance.
module tb_hdmi_pattern_gen;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    hdmi_pattern_gen_if if1 ();
    hdmi_pattern_gen_if if3 ();

    hdmi_pattern_gen #(
        .RESP_LATENCY (1),
        .H_ACTIVE     (64),
        .V_ACTIVE     (8),
        .CHECK_LOG2   (2),
        .SCROLL_STEP  (1)
    ) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1.slave)
    );

    hdmi_pattern_gen #(
        .RESP_LATENCY (3),
        .H_ACTIVE     (64),
        .V_ACTIVE     (8),
        .CHECK_LOG2   (2),
        .SCROLL_STEP  (1)
    ) dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if3.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n     = 0;
    logic [7:0]  off   = 8'd0;
    logic [23:0] hist [0:4095];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @step %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] mode, input logic [23:0] color);
        if1.cfg_mode  = mode;  if3.cfg_mode  = mode;
        if1.cfg_color = color; if3.cfg_color = color;
    endtask

    task automatic drive(input logic en, input logic sof, input logic sol);
        if1.req_en = en;  if3.req_en = en;
        if1.req_sof = sof; if3.req_sof = sof;
        if1.req_sol = sol; if3.req_sol = sol;
    endtask

    task automatic check_resp();
        chk("resp_L1", {8'h00, if1.resp_red, if1.resp_green, if1.resp_blue}, {8'h00, hist[n-1]});
        chk("resp_L3", {8'h00, if3.resp_red, if3.resp_green, if3.resp_blue},
            (n >= 3) ? {8'h00, hist[n-3]} : 32'h0);
    endtask

    // One clock of stimulus; exp is the pixel this cycle's request must return
    task automatic step(input logic en, input logic sof, input logic sol, input logic [23:0] exp);
        @(negedge clk);
        rstn = 1'b1;
        drive(en, sof, sol);
        if (sof) off = off + 8'd1;
        @(posedge clk);
        #1;
        hist[n] = exp;
        n++;
        check_resp();
    endtask

    // Reset cycle: everything still in flight must vanish
    task automatic rst_step();
        @(negedge clk);
        rstn = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        off = 8'd0;
        @(posedge clk);
        #1;
        hist[n] = 24'h0;
        if (n >= 1) hist[n-1] = 24'h0;
        if (n >= 2) hist[n-2] = 24'h0;
        n++;
        check_resp();
    endtask

    task automatic chk_err(input logic exp);
        chk("err_L1", {31'h0, if1.err_overrun}, {31'h0, exp});
        chk("err_L3", {31'h0, if3.err_overrun}, {31'h0, exp});
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    function automatic logic [23:0] scr(input int x);
        logic [7:0] s;
        s = 8'(x) + off;
        return {s, ~s, s};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        set_cfg(3'd0, 24'h0);
        drive(1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (3) rst_step();
        chk_err(1'b0);

        // Solid colour, full line, both latencies
        set_cfg(3'd0, 24'h123456);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 64; x++) step(1, 0, 0, 24'h123456);
        flush();
        chk_err(1'b0);

        // Colour bars, 8 pixels per bar
        set_cfg(3'd1, 24'h123456);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 64; x++) step(1, 0, 0, bars[x/8]);
        flush();
        chk_err(1'b0);

        // Scroll across frames 1 and 3, then offset wrap
        rst_step();
        set_cfg(3'd4, 24'h0);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 10; x++) step(1, 0, 0, scr(x));
        step(1, 0, 0, 24'h0BF40B);
        step(0, 1, 0, 24'h0);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 10; x++) step(1, 0, 0, scr(x));
        step(1, 0, 0, 24'h0DF20D);
        repeat (252) step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        step(1, 0, 0, 24'hFF00FF);
        step(1, 0, 0, 24'h00FF00);
        flush();

        // Checkerboard on line 4; mid-frame mode change must not take effect
        set_cfg(3'd3, 24'h123456);
        step(0, 1, 0, 24'h0);
        repeat (5) step(0, 0, 1, 24'h0);
        for (int x = 0; x < 8; x++) step(1, 0, 0, (x < 4) ? 24'hFFFFFF : 24'h0);
        set_cfg(3'd0, 24'h123456);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 8; x++) step(1, 0, 0, (x < 4) ? 24'hFFFFFF : 24'h0);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 4; x++) step(1, 0, 0, 24'h123456);
        flush();

        // Grid on line 1: lines only at x multiples of 4
        set_cfg(3'd5, 24'h0);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        step(0, 0, 1, 24'h0);
        step(1, 0, 0, 24'hFFFFFF);
        step(1, 0, 0, 24'h000000);
        step(1, 0, 0, 24'h000000);
        step(1, 0, 0, 24'h000000);
        step(1, 0, 0, 24'hFFFFFF);
        flush();

        // Horizontal gradient, offset now 3
        set_cfg(3'd2, 24'h0);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        step(1, 0, 0, 24'h030303);
        step(1, 0, 0, 24'h040404);
        step(1, 0, 0, 24'h050505);
        step(1, 0, 0, 24'h060606);
        flush();
        chk_err(1'b0);

        // 65th pixel on a line is black and sets the sticky error
        set_cfg(3'd0, 24'h123456);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        for (int x = 0; x < 64; x++) step(1, 0, 0, 24'h123456);
        chk_err(1'b0);
        step(1, 0, 0, 24'h000000);
        chk_err(1'b1);
        step(0, 1, 0, 24'h0);
        chk_err(1'b1);
        flush();

        // Ninth line in a frame
        rst_step();
        chk_err(1'b0);
        step(0, 1, 0, 24'h0);
        repeat (8) step(0, 0, 1, 24'h0);
        chk_err(1'b0);
        step(0, 0, 1, 24'h0);
        chk_err(1'b1);
        flush();

        // Reset with pixels in flight: no stale output afterwards
        rst_step();
        set_cfg(3'd0, 24'hABCDEF);
        step(0, 1, 0, 24'h0);
        step(0, 0, 1, 24'h0);
        repeat (3) step(1, 0, 0, 24'hABCDEF);
        rst_step();
        rst_step();
        chk_err(1'b0);
        repeat (4) step(0, 0, 0, 24'h0);

        // Coincident SOF+SOL+req_en renders x=0 with the new offset
        set_cfg(3'd4, 24'h0);
        step(1, 1, 1, 24'h01FE01);
        step(1, 0, 0, 24'h02FD02);
        step(1, 0, 0, 24'h03FC03);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hdmi_pattern_gen.md
Name: hdmi_pattern_gen

Overview:
Parametrised successor to pixel_generate. It sits between hdmi_tx_top's pixel-request interface (req_en/req_sof/req_sol) and its resp_* inputs.
- Tracks x/y position from the request strobes.
- Generates one of six selectable test patterns.
- Returns each pixel exactly RESP_LATENCY cycles after its request.
- Adds frame-synchronous mode switching, per-frame scroll and overrun detection.

Parameters:
RESP_LATENCY, 1, cycles from req_en to resp_*; legal 1..8; must equal hdmi_tx_top's value.
H_ACTIVE, 1280, active pixels per line; must be a multiple of 8.
V_ACTIVE, 720, active lines per frame.
CHECK_LOG2, 5, log2 of checker cell / grid pitch in pixels; legal 1..7.
SCROLL_STEP, 1, scroll offset increment per frame (8-bit, wraps mod 256).

Ports:
clk  input  1  pixel clock; single clock domain.
rstn  input  1  synchronous active-low reset.
cfg_mode  input  3  pattern select; sampled only at req_sof.
cfg_color  input  24  solid colour {R,G,B}; sampled only at req_sof.
req_en  input  1  pixel request, one per active pixel.
req_sof  input  1  start-of-frame pulse, precedes the frame's first req_en.
req_sol  input  1  start-of-line pulse, precedes each line's first req_en.
resp_red  output  8  red response.
resp_green  output  8  green response.
resp_blue  output  8  blue response.
err_overrun  output  1  sticky; set on a geometry violation.

Behaviour:
- Reset (rstn low at a clk edge): resp_* = 0, err_overrun = 0, x = 0, y = 0, offset = 0, mode_q = 0, color_q = 0, first_line = 1, whole delay pipeline cleared. This also applies mid-frame: outputs are 0 from the edge after rstn is sampled low, and stay 0 until a new req_en has traversed the pipeline.
- Counters: x is log2(H_ACTIVE)+1 bits; y is log2(V_ACTIVE)+1 bits; bar_idx is 3 bits; bar_cnt is sized for H_ACTIVE/8.
- req_sof:
  - y <= 0, first_line <= 1.
  - mode_q <= cfg_mode, color_q <= cfg_color.
  - offset <= offset + SCROLL_STEP, wrapping mod 256.
- req_sol:
  - x <= 0, bar_cnt <= 0, bar_idx <= 0.
  - If first_line: first_line <= 0. Otherwise y <= y+1.
  - y saturates at V_ACTIVE; a line with y == V_ACTIVE sets err_overrun.
- req_sof and req_sol in the same cycle: act as a SOF followed by the first SOL, i.e. y = 0 and first_line = 0.
- req_en:
  - The pixel is computed from the pre-update x/y; then x <= x+1.
  - bar_cnt wraps at H_ACTIVE/8-1, and bar_idx increments on that wrap.
- req_en in the same cycle as req_sol: the pixel uses x = 0, then x <= 1.
- Overrun: req_en with x == H_ACTIVE or y == V_ACTIVE → pixel is black, x holds, err_overrun <= 1. err_overrun clears only on reset.
- Patterns by mode_q; let s = (x[7:0] + offset) mod 256:
  - 0 SOLID: color_q.
  - 1 BARS: bar_idx 0..7 selects white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00). No divider is used.
  - 2 HGRAD: R = G = B = s.
  - 3 CHECK: x[CHECK_LOG2] ^ y[CHECK_LOG2] → 1 = white, 0 = black.
  - 4 SCROLL: R = s, G = ~s, B = s (green→purple bars).
  - 5 GRID: white if x[CHECK_LOG2-1:0] == 0 or y[CHECK_LOG2-1:0] == 0, else black.
  - 6, 7: treated as 0.
- Latency:
  - The pattern is registered into stage 1 on the req_en cycle; RESP_LATENCY-1 further stages follow.
  - A valid bit travels alongside the pixel; resp_* = 0 whenever the emerging valid bit is 0.
  - Request at cycle t → response at cycle t+RESP_LATENCY exactly, with no bubbles under back-to-back req_en.
- cfg_* changes mid-frame have no effect until the next req_sof.

Decomposition:
- Package hdmi_pattern_pkg:
  - mode constants MODE_SOLID=0, MODE_BARS=1, MODE_HGRAD=2, MODE_CHECK=3, MODE_SCROLL=4, MODE_GRID=5;
  - the 8-entry bar colour table;
  - colour constants for black and white.
- Sub-module pattern_delay_line: parameters DEPTH and WIDTH (WIDTH = 25: valid + 24-bit RGB). It is a shift register with synchronous active-low clear, and is instantiated with DEPTH = RESP_LATENCY-1, bypassed when that is 0.
- Counters and pattern muxing stay in the top module.

Test Plan:
All scenarios use H_ACTIVE=64, V_ACTIVE=8, CHECK_LOG2=2, SCROLL_STEP=1.
1. RESP_LATENCY=1 and 3, MODE_SOLID, cfg_color=0x123456, SOF+SOL, then 64 back-to-back req_en → exactly 64 responses of R=0x12, G=0x34, B=0x56, each starting L cycles after its req_en; resp_* = 0 otherwise.
2. MODE_BARS, one line → pixels 0..7 white, 8..15 yellow (FF,FF,00), …, 56..63 black.
3. MODE_SCROLL over three frames → frame 1 pixel x=10 gives R=0x0B, G=0xF4; frame 3 pixel x=10 gives R=0x0D, G=0xF2. With offset wrapped to 0xFF, x=1 gives R=0x00.
4. MODE_CHECK, line y=4 → x=0..3 white, x=4..7 black. Change cfg_mode to SOLID mid-frame → no change until the next req_sof.
5. Geometry faults: a 65th req_en on a line → that response is black and err_overrun=1, still set after a later SOF. A 9th SOL in a frame → err_overrun=1.
6. Reset mid-line with RESP_LATENCY=3 (pull rstn low while pixels are in flight) → resp_* = 0 from the next edge, with no stale pixels after rstn rises. A simultaneous SOF+SOL followed by req_en → pixel at x=0, y=0.
